// File: rtl/bus_region_decoder.sv
// Registered memory-map decoder: turns CPU load/store requests into one-hot chip
// selects held for each region's wait-state count, then a done/err response.
module bus_region_decoder #(
  parameter int ADDR_W      = 32,
  parameter int NUM_REGIONS = 3,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = {32'h3000, 32'h2000, 32'h0},
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_SIZE = {32'h100, 32'h1000, 32'h2000},
  parameter logic [NUM_REGIONS*4-1:0]      REGION_WS   = {4'd2, 4'd0, 4'd0},
  parameter logic [NUM_REGIONS-1:0]        REGION_RO   = 3'b001
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  input  logic                   req_write,
  input  logic [ADDR_W-1:0]      req_addr,
  output logic                   req_ready,
  output logic [NUM_REGIONS-1:0] cs,
  output logic                   we,
  output logic                   done,
  output logic                   err,
  output logic [7:0]             err_count,
  output logic [ADDR_W-1:0]      err_addr
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                   state_reg, state_next;
  logic [NUM_REGIONS-1:0]   cs_reg;
  logic                     we_reg;
  logic [3:0]               cnt_reg;
  logic                     fault_reg;
  logic [ADDR_W-1:0]        addr_reg;
  logic [7:0]               err_count_reg;
  logic [ADDR_W-1:0]        err_addr_reg;

  logic [ADDR_W:0]          addr_ext;
  logic [NUM_REGIONS-1:0]   hit_vec;
  logic [NUM_REGIONS-1:0]   hit_onehot;
  logic                     any_hit;
  logic                     hit_ro;
  logic [3:0]               hit_ws;
  logic                     fault;
  logic                     accept;

  assign addr_ext = {1'b0, req_addr};

  // Offset computed one bit wider than the address: an address below the base
  // wraps to >= 2^ADDR_W, which no window size can reach, and a window ending
  // at 2^ADDR_W still matches its last byte.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGIONS; gi++) begin : g_region
      localparam logic [ADDR_W:0] BASE_EXT = {1'b0, REGION_BASE[gi*ADDR_W +: ADDR_W]};
      localparam logic [ADDR_W:0] SIZE_EXT = {1'b0, REGION_SIZE[gi*ADDR_W +: ADDR_W]};
      logic [ADDR_W:0] offset;
      assign offset       = addr_ext - BASE_EXT;
      assign hit_vec[gi]  = offset < SIZE_EXT;
    end
  endgenerate

  // Scan from the top so the lowest-indexed hit is the one that sticks.
  always_comb begin
    any_hit    = 1'b0;
    hit_onehot = '0;
    hit_ro     = 1'b0;
    hit_ws     = 4'd0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        any_hit       = 1'b1;
        hit_onehot    = '0;
        hit_onehot[i] = 1'b1;
        hit_ro        = REGION_RO[i];
        hit_ws        = REGION_WS[i*4 +: 4];
      end
    end
  end

  assign fault  = !any_hit || (req_write && hit_ro);
  assign accept = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = fault ? RESP : ACCESS;
      ACCESS:  if (cnt_reg == 4'd0) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_reg == IDLE) && !reset;
    done      = (state_reg == RESP);
    err       = (state_reg == RESP) && fault_reg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cs_reg        <= '0;
      we_reg        <= 1'b0;
      cnt_reg       <= 4'd0;
      fault_reg     <= 1'b0;
      addr_reg      <= '0;
      err_count_reg <= 8'd0;
      err_addr_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            addr_reg  <= req_addr;
            fault_reg <= fault;
            if (!fault) begin
              cs_reg  <= hit_onehot;
              we_reg  <= req_write;
              cnt_reg <= hit_ws;
            end
          end
        end
        ACCESS: begin
          if (cnt_reg == 4'd0) begin
            cs_reg <= '0;
            we_reg <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        RESP: begin
          if (fault_reg) begin
            if (err_count_reg != 8'hFF) err_count_reg <= err_count_reg + 8'd1;
            err_addr_reg <= addr_reg;
          end
        end
        default: ;
      endcase
    end
  end

  assign cs        = cs_reg;
  assign we        = we_reg;
  assign err_count = err_count_reg;
  assign err_addr  = err_addr_reg;

endmodule

// File: tb/tb_bus_region_decoder.sv
// Bench for bus_region_decoder: default map plus an overlapping / top-of-space
// map, checked cycle by cycle against a window-lookup reference model.
module tb_bus_region_decoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_write = '0;
  logic [31:0] req_addr [2];
  logic [1:0]  req_ready, done, err, we;
  logic [2:0]  cs [2];
  logic [7:0]  err_count [2];
  logic [31:0] err_addr [2];

  int checks = 0;
  int errors = 0;

  longint unsigned base_t [2][3] = '{'{64'h0, 64'h2000, 64'h3000},
                                     '{64'h0, 64'h1000, 64'hFFFF_F000}};
  longint unsigned size_t [2][3] = '{'{64'h2000, 64'h1000, 64'h100},
                                     '{64'h1800, 64'h1000, 64'h1000}};
  int              ws_t   [2][3] = '{'{0, 0, 2}, '{0, 3, 1}};
  bit              ro_t   [2][3] = '{'{1'b1, 1'b0, 1'b0}, '{1'b0, 1'b1, 1'b0}};

  int          exp_cnt [2];
  logic [31:0] exp_eaddr [2];

  always #5 clk = ~clk;

  bus_region_decoder dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_write(req_write[0]), .req_addr(req_addr[0]),
    .req_ready(req_ready[0]), .cs(cs[0]), .we(we[0]), .done(done[0]), .err(err[0]),
    .err_count(err_count[0]), .err_addr(err_addr[0])
  );

  bus_region_decoder #(
    .ADDR_W(32), .NUM_REGIONS(3),
    .REGION_BASE({32'hFFFF_F000, 32'h1000, 32'h0}),
    .REGION_SIZE({32'h1000, 32'h1000, 32'h1800}),
    .REGION_WS({4'd1, 4'd3, 4'd0}),
    .REGION_RO(3'b010)
  ) dut1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_write(req_write[1]), .req_addr(req_addr[1]),
    .req_ready(req_ready[1]), .cs(cs[1]), .we(we[1]), .done(done[1]), .err(err[1]),
    .err_count(err_count[1]), .err_addr(err_addr[1])
  );

  // Reference: first window (lowest index) containing the address, 64-bit math.
  function automatic void model(input int d, input logic [31:0] a, input logic wr,
                                output logic f, output logic [2:0] c, output int ws);
    longint unsigned aa = 64'(a);
    bit found = 1'b0;
    f = 1'b1; c = 3'b000; ws = 0;
    for (int r = 0; r < 3; r++) begin
      if (!found && aa >= base_t[d][r] && aa < base_t[d][r] + size_t[d][r]) begin
        found = 1'b1;
        c     = 3'(1 << r);
        ws    = ws_t[d][r];
        f     = wr && ro_t[d][r];
      end
    end
  endfunction

  // Expected {req_ready, done, err, cs, we} in cycle k after acceptance.
  function automatic logic [6:0] expv(input logic f, input logic [2:0] c, input int ws,
                                      input logic wr, input int k);
    if (f) return (k == 1) ? 7'b0110000 : 7'b1000000;
    if (k <= ws + 1) return {3'b000, c, wr};
    if (k == ws + 2) return 7'b0100000;
    return 7'b1000000;
  endfunction

  function automatic logic [6:0] actv(input int d);
    return {req_ready[d], done[d], err[d], cs[d], we[d]};
  endfunction

  task automatic run_access(input int d, input logic wr, input logic [31:0] addr,
                            input string name);
    logic f; logic [2:0] c; int ws; int n;
    logic [6:0] e, a;
    model(d, addr, wr, f, c, ws);
    n = f ? 2 : ws + 3;
    @(negedge clk);
    checks++;
    if (req_ready[d] !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_before: got %b expected 1", name, req_ready[d]);
    end
    req_valid[d] = 1'b1; req_write[d] = wr; req_addr[d] = addr;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req_valid[d] = 1'b0; req_write[d] = 1'($urandom); req_addr[d] = $urandom;
      end
      e = expv(f, c, ws, wr, k);
      a = actv(d);
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s addr=%h cycle %0d {rdy,done,err,cs,we}: got %b expected %b",
                 name, addr, k, a, e);
      end
    end
    if (f) begin
      if (exp_cnt[d] < 255) exp_cnt[d]++;
      exp_eaddr[d] = addr;
    end
    checks++;
    if (err_count[d] !== 8'(exp_cnt[d]) || err_addr[d] !== exp_eaddr[d]) begin
      errors++;
      $display("FAIL %s err_log: got count=%0d addr=%h expected count=%0d addr=%h",
               name, err_count[d], err_addr[d], exp_cnt[d], exp_eaddr[d]);
    end
    $display("dut%0d %s %s addr=%h fault=%b cs=%b ws=%0d", d, name, wr ? "store" : "load",
             addr, f, c, ws);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_addr[0] = '0; req_addr[1] = '0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (actv(d) !== 7'b0 || err_count[d] !== 8'd0 || err_addr[d] !== 32'd0) begin
        errors++;
        $display("FAIL reset dut%0d: got %b cnt=%0d addr=%h expected all zero",
                 d, actv(d), err_count[d], err_addr[d]);
      end
      exp_cnt[d] = 0; exp_eaddr[d] = '0;
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b11) begin
      errors++;
      $display("FAIL reset_release ready: got %b expected 11", req_ready);
    end
  endtask

  task automatic test_directed();
    run_access(0, 1'b0, 32'h0000_0100, "load_rom");
    run_access(0, 1'b1, 32'h0000_2FFC, "store_ram");
    run_access(0, 1'b1, 32'h0000_3000, "store_ws2");
    run_access(0, 1'b1, 32'h0000_0010, "store_ro");
    run_access(0, 1'b0, 32'h0000_4000, "load_unmapped");
  endtask

  task automatic test_boundaries();
    run_access(0, 1'b0, 32'h0000_1FFF, "bnd_1fff");
    run_access(0, 1'b0, 32'h0000_2000, "bnd_2000");
    run_access(0, 1'b0, 32'h0000_30FF, "bnd_30ff");
    run_access(0, 1'b0, 32'h0000_3100, "bnd_3100");
    run_access(1, 1'b0, 32'h0000_1400, "ovl_low");
    run_access(1, 1'b1, 32'h0000_17FF, "ovl_edge");
    run_access(1, 1'b0, 32'h0000_1800, "ovl_r1");
    run_access(1, 1'b1, 32'h0000_1900, "ovl_r1_ro");
    run_access(1, 1'b1, 32'hFFFF_FFFF, "top_last");
    run_access(1, 1'b0, 32'hFFFF_F000, "top_first");
    run_access(1, 1'b0, 32'hFFFF_EFFF, "top_below");
    run_access(1, 1'b0, 32'h0000_2000, "dut1_gap");
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int i = 0; i < 40; i++) begin
      a = 32'($urandom_range(0, 32'h3200));
      run_access(0, 1'($urandom), a, "rand0");
      if ($urandom_range(0, 1) == 0) a = 32'($urandom_range(0, 32'h2100));
      else a = 32'hFFFF_E000 + 32'($urandom_range(0, 32'h1FFF));
      run_access(1, 1'($urandom), a, "rand1");
    end
  endtask

  task automatic test_back_to_back();
    logic f; logic [2:0] c; int ws; int n; logic wr;
    logic [31:0] a;
    logic [6:0] e;
    int k = 0;
    int accepted = 0;
    f = 1'b0; c = '0; ws = 0; n = 0; wr = 1'b0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      @(negedge clk);
      e = (k == 0) ? 7'b1000000 : expv(f, c, ws, wr, k);
      checks++;
      if (actv(0) !== e) begin
        errors++;
        $display("FAIL b2b cycle %0d k=%0d: got %b expected %b", cyc, k, actv(0), e);
      end
      a  = 32'($urandom_range(0, 32'h3200));
      req_valid[0] = 1'b1; req_addr[0] = a;
      if (k == 0 || k == n) begin
        wr = 1'($urandom);
        req_write[0] = wr;
        model(0, a, wr, f, c, ws);
        n = f ? 2 : ws + 3;
        if (f) begin
          if (exp_cnt[0] < 255) exp_cnt[0]++;
          exp_eaddr[0] = a;
        end
        accepted++;
        $display("dut0 b2b accept cycle %0d addr=%h wr=%b fault=%b", cyc, a, wr, f);
        k = 1;
      end else begin
        req_write[0] = 1'($urandom);
        k++;
      end
    end
    req_valid[0] = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if (err_count[0] !== 8'(exp_cnt[0]) || err_addr[0] !== exp_eaddr[0]) begin
      errors++;
      $display("FAIL b2b err_log: got count=%0d addr=%h expected count=%0d addr=%h",
               err_count[0], err_addr[0], exp_cnt[0], exp_eaddr[0]);
    end
    $display("dut0 b2b accepted %0d requests", accepted);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 32'h0000_3000;
    @(negedge clk);
    req_valid[0] = 1'b0;
    checks++;
    if (actv(0) !== 7'b0001001) begin
      errors++;
      $display("FAIL midrst cycle1: got %b expected 0001001", actv(0));
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (actv(0) !== 7'b0 || err_count[0] !== 8'd0 || err_addr[0] !== 32'd0) begin
      errors++;
      $display("FAIL midrst during_reset: got %b cnt=%0d addr=%h expected zeros",
               actv(0), err_count[0], err_addr[0]);
    end
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin exp_cnt[d] = 0; exp_eaddr[d] = '0; end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (actv(0) !== 7'b1000000) begin
        errors++;
        $display("FAIL midrst after_%0d: got %b expected 1000000", k, actv(0));
      end
    end
    $display("dut0 reset mid-access done");
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 256; i++)
      run_access(0, 1'($urandom), 32'h0000_4000 + ($urandom & 32'h0FFF_FFFF), "sat");
    checks++;
    if (err_count[0] !== 8'd255) begin
      errors++;
      $display("FAIL saturation: got %0d expected 255", err_count[0]);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_boundaries();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
